// File: rtl/int_vector_seq.sv
// int_vector_seq: arbitrates RESET/NMI/IRQ/BRK and sequences the three
// stack pushes plus the two-byte vector fetch into the PC register.
module int_vector_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic        i_flag,
  input  logic [7:0]  pcl_in,
  input  logic [7:0]  pch_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [1:0]  src,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        sp_dec,
  output logic        pc_load_l,
  output logic        pc_load_h_mem,
  output logic        set_i,
  output logic        done
);

  localparam logic [1:0] SRC_RST = 2'd0;
  localparam logic [1:0] SRC_NMI = 2'd1;
  localparam logic [1:0] SRC_IRQ = 2'd2;
  localparam logic [1:0] SRC_BRK = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_H = 3'd1,
    S_PUSH_L = 3'd2,
    S_PUSH_P = 3'd3,
    S_VEC_L  = 3'd4,
    S_VEC_H  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_src;
  logic [1:0]  w_next_src;
  logic        r_nmi_n;
  logic        r_nmi_pending;
  logic        w_nmi_edge;
  logic        w_accept_nmi;
  logic [15:0] w_vec;
  logic [15:0] w_stack_addr;

  // The PC low byte is loaded from memory data; its live value is not needed here.
  logic        w_unused;
  assign w_unused = ^mem_rdata;

  assign w_nmi_edge   = r_nmi_n & ~nmi_n;
  assign w_stack_addr = {STACK_PAGE, sp_in};
  assign src          = r_src;

  // State, latched source and NMI edge-detect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_PUSH_H;
      r_src         <= SRC_RST;
      r_nmi_n       <= 1'b1;
      r_nmi_pending <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_src         <= w_next_src;
      r_nmi_n       <= nmi_n;
      r_nmi_pending <= (r_nmi_pending & ~w_accept_nmi) | w_nmi_edge;
    end
  end

  // Vector selection from the latched source.
  always_comb begin
    w_vec = VEC_IRQ;
    case (r_src)
      SRC_RST: w_vec = VEC_RST;
      SRC_NMI: w_vec = VEC_NMI;
      default: w_vec = VEC_IRQ;
    endcase
  end

  // Next-state, arbitration and Moore output decode; reset forces strobes low.
  always_comb begin
    w_next_state  = r_state;
    w_next_src    = r_src;
    w_accept_nmi  = 1'b0;
    busy          = 1'b1;
    mem_addr      = 16'h0000;
    mem_wdata     = 8'h00;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    sp_dec        = 1'b0;
    pc_load_l     = 1'b0;
    pc_load_h_mem = 1'b0;
    set_i         = 1'b0;
    done          = 1'b0;

    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          busy = 1'b0;
          if (instr_boundary) begin
            if (r_nmi_pending) begin
              w_next_state = S_PUSH_H;
              w_next_src   = SRC_NMI;
              w_accept_nmi = 1'b1;
            end else if (!irq_n && !i_flag) begin
              w_next_state = S_PUSH_H;
              w_next_src   = SRC_IRQ;
            end else if (brk_req) begin
              w_next_state = S_PUSH_H;
              w_next_src   = SRC_BRK;
            end
          end
        end
        S_PUSH_H: begin
          mem_addr     = w_stack_addr;
          mem_wdata    = pch_in;
          mem_we       = (r_src != SRC_RST);
          sp_dec       = 1'b1;
          w_next_state = S_PUSH_L;
        end
        S_PUSH_L: begin
          mem_addr     = w_stack_addr;
          mem_wdata    = pcl_in;
          mem_we       = (r_src != SRC_RST);
          sp_dec       = 1'b1;
          w_next_state = S_PUSH_P;
        end
        S_PUSH_P: begin
          mem_addr     = w_stack_addr;
          mem_wdata    = {p_in[7:6], 1'b1, (r_src == SRC_BRK), p_in[3:0]};
          mem_we       = (r_src != SRC_RST);
          sp_dec       = 1'b1;
          w_next_state = S_VEC_L;
        end
        S_VEC_L: begin
          mem_addr     = w_vec;
          mem_re       = 1'b1;
          w_next_state = S_VEC_H;
        end
        S_VEC_H: begin
          mem_addr     = 16'(w_vec + 16'd1);
          mem_re       = 1'b1;
          pc_load_l    = 1'b1;
          w_next_state = S_FINISH;
        end
        S_FINISH: begin
          pc_load_h_mem = 1'b1;
          set_i         = 1'b1;
          done          = 1'b1;
          w_next_state  = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_vector_seq.sv
// Directed bench for int_vector_seq with small PC/SP/vector-memory models.
module tb_int_vector_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        instr_boundary;
  logic        i_flag;
  logic [7:0]  pcl_q;
  logic [7:0]  pch_q;
  logic [7:0]  p_in;
  logic [7:0]  sp_q;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [1:0]  src;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        sp_dec;
  logic        pc_load_l;
  logic        pc_load_h_mem;
  logic        set_i;
  logic        done;

  logic        pc_set;
  logic [15:0] pc_val;
  logic        sp_set;
  logic [7:0]  sp_val;
  logic [7:0]  vmem [0:5];

  int n_chk = 0;
  int n_err = 0;

  int_vector_seq dut (
    .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .brk_req(brk_req),
    .instr_boundary(instr_boundary), .i_flag(i_flag),
    .pcl_in(pcl_q), .pch_in(pch_q), .p_in(p_in), .sp_in(sp_q),
    .mem_rdata(mem_rdata), .busy(busy), .src(src), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .sp_dec(sp_dec),
    .pc_load_l(pc_load_l), .pc_load_h_mem(pc_load_h_mem), .set_i(set_i),
    .done(done)
  );

  always #5 clk = ~clk;

  // Vector ROM read port (one-cycle latency), PC register and stack pointer.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= vmem[3'(mem_addr - 16'hFFFA)];
    if (pc_set) {pch_q, pcl_q} <= pc_val;
    else begin
      if (pc_load_l)     pcl_q <= mem_rdata;
      if (pc_load_h_mem) pch_q <= mem_rdata;
    end
    if (sp_set)      sp_q <= sp_val;
    else if (sp_dec) sp_q <= sp_q - 8'd1;
  end

  wire [7:0] w_strb = {busy, mem_we, mem_re, sp_dec, pc_load_l, pc_load_h_mem, set_i, done};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request at a boundary; busy must stay low in the acceptance cycle.
  task automatic accept();
    instr_boundary = 1'b1;
    #1;
    chk("acc_busy", 16'(busy), 16'h0);
    tick();
    instr_boundary = 1'b0;
    brk_req        = 1'b0;
    #1;
  endtask

  // Checks six busy cycles starting in PUSH_H, then the IDLE cycle after FINISH.
  task automatic expect_seq(input logic [1:0] s, input logic [15:0] vec, input logic wr,
                            input logic [7:0] sp0, input logic [7:0] pch, input logic [7:0] pcl,
                            input logic [7:0] pw, input logic [15:0] pc_exp, input int nmi_k);
    logic [7:0] data [0:2];
    logic [7:0] exp_strb;
    data[0] = pch;
    data[1] = pcl;
    data[2] = pw;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0, 1, 2: exp_strb = {1'b1, wr, 6'b010000};
        3:       exp_strb = 8'b1010_0000;
        4:       exp_strb = 8'b1010_1000;
        default: exp_strb = 8'b1000_0111;
      endcase
      chk($sformatf("strb%0d", k), 16'(w_strb), 16'(exp_strb));
      chk($sformatf("src%0d", k), 16'(src), 16'(s));
      if (k < 3 && wr) begin
        chk($sformatf("waddr%0d", k), mem_addr, {8'h01, 8'(sp0 - 8'(k))});
        chk($sformatf("wdata%0d", k), 16'(mem_wdata), 16'(data[k]));
      end
      if (k == 3) chk("vaddr_l", mem_addr, vec);
      if (k == 4) chk("vaddr_h", mem_addr, 16'(vec + 16'd1));
      if (k == nmi_k) nmi_n = 1'b0;
      tick();
    end
    chk("idle_strb", 16'(w_strb), 16'h0);
    chk("pc", {pch_q, pcl_q}, pc_exp);
    chk("sp", 16'(sp_q), 16'(8'(sp0 - 8'd3)));
  endtask

  initial begin
    rst = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
    instr_boundary = 1'b0; i_flag = 1'b0; p_in = 8'h24;
    pc_set = 1'b0; pc_val = 16'h0000; sp_set = 1'b1; sp_val = 8'h00;
    vmem[0] = 8'h00; vmem[1] = 8'h90;   // NMI  -> 9000
    vmem[2] = 8'h34; vmem[3] = 8'h12;   // RST  -> 1234
    vmem[4] = 8'h00; vmem[5] = 8'h80;   // IRQ  -> 8000

    // Reset held over two edges: only busy is asserted, bus idle.
    tick();
    sp_set = 1'b0;
    chk("rst_strb0", 16'(w_strb), 16'h0080);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", 16'(mem_wdata), 16'h0000);
    tick();
    chk("rst_strb1", 16'(w_strb), 16'h0080);
    chk("rst_src", 16'(src), 16'h0);
    rst = 1'b0;
    #1;
    expect_seq(2'd0, 16'hFFFC, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1234, -1);

    // Boundary with nothing pending stays idle.
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    #1;
    chk("noreq_idle", 16'(busy), 16'h0);

    // IRQ: PC=C123, P=24, SP=FD.
    pc_set = 1'b1; pc_val = 16'hC123; sp_set = 1'b1; sp_val = 8'hFD;
    tick();
    pc_set = 1'b0; sp_set = 1'b0;
    irq_n = 1'b0; i_flag = 1'b0;
    accept();
    irq_n = 1'b1;
    expect_seq(2'd2, 16'hFFFE, 1'b1, 8'hFD, 8'hC1, 8'h23, 8'h24, 16'h8000, -1);

    // BRK taken despite I set; pushed P has the B bit.
    i_flag = 1'b1; brk_req = 1'b1;
    accept();
    expect_seq(2'd3, 16'hFFFE, 1'b1, 8'hFA, 8'h80, 8'h00, 8'h34, 16'h8000, -1);

    // NMI edge pending plus IRQ low at the same boundary: NMI wins.
    nmi_n = 1'b0;
    tick();
    irq_n = 1'b0; i_flag = 1'b0;
    accept();
    expect_seq(2'd1, 16'hFFFA, 1'b1, 8'hF7, 8'h80, 8'h00, 8'h24, 16'h9000, -1);
    // NMI held low does not retrigger; IRQ masked while I=1.
    i_flag = 1'b1; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    #1;
    chk("masked_idle", 16'(busy), 16'h0);
    i_flag = 1'b0;
    accept();
    irq_n = 1'b1;
    expect_seq(2'd2, 16'hFFFE, 1'b1, 8'hF4, 8'h90, 8'h00, 8'h24, 16'h8000, -1);
    nmi_n = 1'b1;
    tick();

    // NMI falls in VEC_L of an IRQ: IRQ completes, NMI follows at next boundary.
    irq_n = 1'b0;
    accept();
    irq_n = 1'b1;
    expect_seq(2'd2, 16'hFFFE, 1'b1, 8'hF1, 8'h80, 8'h00, 8'h24, 16'h8000, 3);
    accept();
    expect_seq(2'd1, 16'hFFFA, 1'b1, 8'hEE, 8'h80, 8'h00, 8'h24, 16'h9000, -1);
    nmi_n = 1'b1;
    tick();

    // Reset in PUSH_L of an IRQ, with an NMI edge already latched.
    irq_n = 1'b0;
    accept();
    irq_n = 1'b1;
    nmi_n = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_strb", 16'(w_strb), 16'h0080);
    chk("midrst_addr", mem_addr, 16'h0000);
    nmi_n = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    expect_seq(2'd0, 16'hFFFC, 1'b0, 8'hEA, 8'h00, 8'h00, 8'h00, 16'h1234, -1);
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    #1;
    chk("nmi_cleared", 16'(busy), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/int_vector_seq.md
# int_vector_seq

Interrupt/reset vector sequencer for the 2A03 core. It arbitrates between RESET, NMI, IRQ and BRK, then sequences the stack pushes and the two-byte vector fetch. It drives the PC register's load strobes (low byte, then high byte from memory) and owns the memory bus for the duration of the sequence. It sits between the instruction decoder (boundary/BRK signals), the interrupt pins, the SP/P registers and the PC register.

## Interface
Parameters:
- STACK_PAGE, 8'h01, high address byte for stack writes
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RST, 16'hFFFC, RESET vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- nmi_n  in  1  NMI pin, falling-edge sensitive
- irq_n  in  1  IRQ pin, level-sensitive, active-low
- brk_req  in  1  decoder has decoded BRK; sampled only at instr_boundary
- instr_boundary  in  1  core is at an opcode-fetch boundary this cycle
- i_flag  in  1  P.I interrupt-disable bit
- pcl_in / pch_in  in  8 / 8  current PC
- p_in  in  8  current status register
- sp_in  in  8  current stack pointer
- mem_rdata  in  8  memory read data, valid the cycle after mem_re
- busy  out  1  sequence in progress; core must stall
- src  out  2  active source: 0 RESET, 1 NMI, 2 IRQ, 3 BRK
- mem_addr  out  16  bus address
- mem_wdata  out  8  bus write data
- mem_we / mem_re  out  1 / 1  write / read strobes
- sp_dec  out  1  decrement SP at the end of this cycle
- pc_load_l  out  1  PCL <= mem_rdata this edge
- pc_load_h_mem  out  1  PCH <= mem_rdata this edge
- set_i  out  1  set P.I this edge
- done  out  1  one-cycle pulse on the final cycle

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, FINISH. Outputs are Moore-decoded from state and the latched src.
- IDLE: busy=0, all strobes 0. At a cycle with instr_boundary=1, the pending source with highest priority is accepted and the FSM moves to PUSH_H. Priority order: nmi_pending, then IRQ (irq_n=0 and i_flag=0), then brk_req.
- NMI edge detect: nmi_n is registered. A 1->0 transition sets nmi_pending. nmi_pending clears only in the cycle the NMI is accepted. An edge during any busy state stays pending. Vector hijacking is not performed.
- PUSH_H: mem_addr={STACK_PAGE,sp_in}, mem_wdata=pch_in, mem_we=1, sp_dec=1.
- PUSH_L: same as PUSH_H, with mem_wdata=pcl_in. sp_in has already been decremented externally.
- PUSH_P: mem_wdata=p_in with bit5=1, bit4=1 for BRK and 0 otherwise; mem_we=1, sp_dec=1.
- RESET source: the three PUSH states assert sp_dec=1 with mem_we=0, so no writes occur.
- VEC_L: mem_re=1, mem_addr=vector (NMI→VEC_NMI, RESET→VEC_RST, IRQ/BRK→VEC_IRQ).
- VEC_H: mem_re=1, mem_addr=vector+1, pc_load_l=1 (mem_rdata carries the low byte).
- FINISH: pc_load_h_mem=1, set_i=1, done=1. Next state is IDLE.
- src holds from acceptance through FINISH. In IDLE it holds its last value.
- At most one of pc_load_l / pc_load_h_mem is high in any cycle.

## Timing
- rst=1:
  - State is forced to PUSH_H with src=0. Any in-progress sequence is aborted.
  - nmi_pending=0 and the nmi_n register is set to 1.
  - All strobes (mem_we, mem_re, sp_dec, pc_load_*, set_i, done) are 0.
  - busy=1, mem_addr=0, mem_wdata=0.
- Reset sequence: the first cycle with rst=0 is PUSH_H. done follows 5 cycles later (6 busy cycles total). Then IDLE.
- Interrupt/BRK accepted at cycle T: PUSH_H at T+1, PUSH_L at T+2, PUSH_P at T+3, VEC_L at T+4, VEC_H at T+5, FINISH at T+6, IDLE at T+7.
- busy is high in T+1..T+6 and low in the acceptance cycle.
- Requests arriving while busy=1 are ignored until IDLE. IRQ is level-sensitive, so it is re-evaluated at the next boundary after FINISH. Because set_i fires in FINISH, an IRQ is then masked if P.I took effect.
- NMI edge and IRQ in the same boundary cycle: NMI is taken and IRQ remains level-pending.
- An NMI edge in the exact acceptance cycle of an IRQ/BRK is latched and serviced at the next boundary.
- instr_boundary=1 with no request: the FSM stays in IDLE.

## Test plan
- Reset:
  - Stimulus: rst high for 2 cycles, then low; memory[FFFC]=34, [FFFD]=12, sp_in starts at 00.
  - Required response: no mem_we; sp_dec pulses 3 times; pc_load_l, then pc_load_h_mem, with PC=1234; done 6 cycles after rst falls; src=0.
- IRQ:
  - Stimulus: i_flag=0, irq_n=0 at boundary; PC=C123, P=24, SP=FD.
  - Required response: writes 01FD←C1, 01FC←23, 01FB←24 (bit4=0); vector read at FFFE/FFFF; set_i in FINISH.
- BRK:
  - Stimulus: brk_req=1 at boundary with i_flag=1.
  - Required response: taken despite i_flag; pushed P has bit4=1; vector FFFE.
- NMI priority and edge:
  - Stimulus: nmi_n falling plus irq_n=0 at the same boundary.
  - Required response: NMI taken with vector FFFA. nmi_n held low afterwards does not retrigger. IRQ is serviced only if i_flag=0 at the next boundary.
- NMI during a sequence:
  - Stimulus: nmi_n falls in VEC_L of an IRQ sequence.
  - Required response: the IRQ completes unchanged; the NMI is accepted at the first boundary after IDLE.
- Reset mid-sequence:
  - Stimulus: rst asserted in PUSH_L of an IRQ.
  - Required response: strobes drop to 0 that cycle; no further pushes; a full reset sequence to the FFFC vector follows; nmi_pending is cleared.
